// File: rtl/rv_pkg.sv
// rv_pkg: shared constants for the instruction/data memory arbiter.
// Requester IDs, default widths and the counter-width helper.
package rv_pkg;

  localparam logic RQ_IF = 1'b0;
  localparam logic RQ_D  = 1'b1;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;
  localparam int DEPTH_DEF = 2;
  localparam int STARVE_MAX_DEF = 4;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/rv_id_fifo.sv
// rv_id_fifo: small synchronous FIFO with full/empty/count.
// DEPTH must be a power of 2 so the pointers wrap by overflow.
module rv_id_fifo
  import rv_pkg::*;
#(
  parameter int W = 1,
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [W-1:0]            wdata,
  input  logic                    pop,
  output logic [W-1:0]            rdata,
  output logic                    full,
  output logic                    empty,
  output logic [cnt_w(DEPTH)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [W-1:0]  slots [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = slots[rd_ptr];

  // pointer, occupancy and storage update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slots[i] <= '0;
      end
    end else begin
      if (do_push) begin
        slots[wr_ptr] <= wdata;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/rv_mem_arbiter.sv
// rv_mem_arbiter: shares one memory port between fetch and load/store.
// RV_ARB_RR_EN selects round-robin instead of D-priority with starve override.
module rv_mem_arbiter
  import rv_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          err
);

  localparam int CW = cnt_w(DEPTH);

  logic          fifo_full;
  logic          fifo_empty;
  logic          head;
  logic [CW-1:0] fifo_count;
  logic          unused_count;
  logic          pick_if;
  logic          xfer;
  logic          rsp_ok;

  assign unused_count = ^fifo_count;

  // issue side: full blocks issue even on a same-cycle pop
  assign mem_req   = reset & (if_req | d_req) & ~fifo_full;
  assign xfer      = mem_req & mem_gnt;
  assign if_gnt    = xfer & pick_if;
  assign d_gnt     = xfer & ~pick_if;
  assign mem_we    = pick_if ? 1'b0 : d_we;
  assign mem_addr  = pick_if ? if_addr : d_addr;
  assign mem_wdata = d_wdata;
  assign mem_be    = pick_if ? '1 : d_be;

  // response side: head of the ID FIFO picks the destination
  assign rsp_ok    = mem_rvalid & ~fifo_empty;
  assign if_rvalid = rsp_ok & (head == RQ_IF);
  assign d_rvalid  = rsp_ok & (head == RQ_D);
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

`ifdef RV_ARB_RR_EN
  logic last_win;

  assign pick_if = if_req & (~d_req | (last_win == RQ_D));

  // contended transfers hand preference to the other side
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_win <= RQ_IF;
    end else if (xfer & if_req & d_req) begin
      last_win <= pick_if ? RQ_IF : RQ_D;
    end
  end
`else
  localparam int SW = cnt_w(STARVE_MAX);

  logic [SW-1:0] starve_cnt;
  logic          starved;

  assign starved = starve_cnt == SW'(STARVE_MAX);
  assign pick_if = if_req & (~d_req | starved);

  // count consecutive fetch losses, saturating
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (~if_req | if_gnt) begin
      starve_cnt <= '0;
    end else if (d_gnt & ~starved) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end
`endif

  // sticky flag for a response with nothing outstanding
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else if (mem_rvalid & fifo_empty) begin
      err <= 1'b1;
    end
  end

  rv_id_fifo #(
    .W     (1),
    .DEPTH (DEPTH)
  ) u_ids (
    .clk   (clk),
    .reset (reset),
    .push  (xfer),
    .wdata (pick_if ? RQ_IF : RQ_D),
    .pop   (rsp_ok),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// tb_rv_mem_arbiter: directed and random checks of the memory arbiter
// against a queue-based model of the outstanding transactions.
module tb_rv_mem_arbiter;
  import rv_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int DEPTH = 2;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [BW-1:0] d_be = '0;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          err;

  rv_mem_arbiter #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH), .STARVE_MAX(SM)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // model: tags of outstanding transfers (0 IF, 1 D load, 2 D store)
  int    ids[$];
  int    starve = 0;
  bit    pref_if = 1'b0;
  bit    err_m = 1'b0;
  string glog = "";

  logic          s_mem_req, s_if_gnt, s_d_gnt;
  logic          s_if_rv, s_d_rv, s_err;
  logic [DW-1:0] s_if_rd, s_d_rd;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_log(input string nm, input string exp);
    total++;
    if (glog != exp) begin
      bad++;
      $display("FAIL %s got=%s want=%s", nm, glog, exp);
    end
  endtask

  // compare DUT against the model, then advance the model one edge
  task automatic step();
    bit full, req, pif, xf, rok;
    int tag;
    full = ids.size() >= DEPTH;
    req = (if_req || d_req) && !full;
`ifdef RV_ARB_RR_EN
    pif = if_req && (!d_req || pref_if);
`else
    pif = if_req && (!d_req || starve == SM);
`endif
    xf = req && mem_gnt;
    rok = mem_rvalid && ids.size() > 0;
    tag = rok ? ids[0] : -1;
    s_mem_req = mem_req; s_if_gnt = if_gnt; s_d_gnt = d_gnt;
    s_if_rv = if_rvalid; s_d_rv = d_rvalid; s_err = err;
    s_if_rd = if_rdata; s_d_rd = d_rdata;
    chk("mem_req", mem_req, req);
    chk("if_gnt", if_gnt, xf && pif);
    chk("d_gnt", d_gnt, xf && !pif);
    chk("if_rvalid", if_rvalid, tag == 0);
    chk("d_rvalid", d_rvalid, tag > 0);
    if (tag == 0) chk("if_rdata", if_rdata, mem_rdata);
    if (tag == 1) chk("d_rdata", d_rdata, mem_rdata);
    chk("err", err, err_m);
    if (req) begin
      chk("mem_we", mem_we, !pif && d_we);
      chk("mem_addr", mem_addr, pif ? if_addr : d_addr);
      chk("mem_be", mem_be, pif ? {BW{1'b1}} : d_be);
      if (!pif && d_we) chk("mem_wdata", mem_wdata, d_wdata);
    end
    if (if_gnt) glog = {glog, "I"};
    else if (d_gnt) glog = {glog, "D"};
    if (mem_rvalid && ids.size() == 0) err_m = 1'b1;
    if (rok) void'(ids.pop_front());
    if (xf) ids.push_back(pif ? 0 : (d_we ? 2 : 1));
    if (!if_req || (xf && pif)) starve = 0;
    else if (xf && starve < SM) starve++;
    if (xf && if_req && d_req) pref_if = !pif;
  endtask

  task automatic cycle();
    @(negedge clk);
    step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    if_req = 0; d_req = 0; mem_gnt = 0; mem_rvalid = 0;
    reset = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1;
    ids.delete();
    starve = 0;
    pref_if = 1'b0;
    err_m = 1'b0;
    glog = "";
  endtask

  initial begin
    // reset state with every input pushing for activity
    if_req = 1; d_req = 1; mem_gnt = 1; mem_rvalid = 1;
    #12;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_if_rv", if_rvalid, 0);
    chk("rst_d_rv", d_rvalid, 0);
    chk("rst_err", err, 0);

    // IF only, responses held back until the FIFO fills
    do_reset();
    if_req = 1; if_addr = 32'h0; mem_gnt = 1;
    cycle();
    if_addr = 32'h4;
    cycle();
    if_addr = 32'h8; mem_rvalid = 1; mem_rdata = 32'hA;
    cycle();
    chk("full_req", s_mem_req, 0);
    chk("full_gnt", s_if_gnt, 0);
    chk("full_rv", s_if_rv, 1);
    chk("full_rd", s_if_rd, 32'hA);
    mem_rdata = 32'hB;
    cycle();
    chk("refill_gnt", s_if_gnt, 1);
    chk("refill_rd", s_if_rd, 32'hB);
    if_req = 0; mem_rdata = 32'hC;
    cycle();
    chk("last_rd", s_if_rd, 32'hC);
    chk("last_drv", s_d_rv, 0);
    chk_log("ifonly_seq", "III");

    // contention with 1-cycle responses
    do_reset();
    if_req = 1; d_req = 1; d_we = 0; mem_gnt = 1;
    if_addr = 32'h100; d_addr = 32'h800;
    for (int i = 0; i < 40 && glog.len() < 10; i++) begin
      mem_rvalid = ids.size() > 0;
      mem_rdata = $urandom();
      cycle();
      if (s_if_gnt) if_addr = if_addr + 4;
      if (s_d_gnt) d_addr = d_addr + 4;
    end
`ifdef RV_ARB_RR_EN
    chk_log("contend_seq", "DIDIDIDIDI");
`else
    chk_log("contend_seq", "DDDDIDDDDI");
`endif

    // interleaved routing IF, D load, IF
    do_reset();
    if_req = 1; if_addr = 32'h10; mem_gnt = 1;
    cycle();
    if_req = 0; d_req = 1; d_we = 0; d_addr = 32'h200;
    mem_rvalid = 1; mem_rdata = 32'hA;
    cycle();
    chk("rt_a_rv", s_if_rv, 1);
    chk("rt_a_rd", s_if_rd, 32'hA);
    d_req = 0; if_req = 1; if_addr = 32'h14; mem_rdata = 32'hB;
    cycle();
    chk("rt_b_rv", s_d_rv, 1);
    chk("rt_b_rd", s_d_rd, 32'hB);
    chk("rt_b_ifrv", s_if_rv, 0);
    if_req = 0; mem_rdata = 32'hC;
    cycle();
    chk("rt_c_rv", s_if_rv, 1);
    chk("rt_c_rd", s_if_rd, 32'hC);

    // stray response with an empty FIFO
    do_reset();
    mem_rvalid = 1; mem_rdata = 32'h5;
    cycle();
    mem_rvalid = 0;
    cycle();
    chk("stray_err", s_err, 1);
    cycle();
    chk("stray_sticky", s_err, 1);
    do_reset();
    cycle();
    chk("stray_clr", s_err, 0);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (!if_req || s_if_gnt) begin
        if_req = $urandom_range(0, 2) != 0;
        if_addr = $urandom() & ~32'h3;
      end
      if (!d_req || s_d_gnt) begin
        d_req = $urandom_range(0, 2) != 0;
        d_we = $urandom_range(0, 1) != 0;
        d_addr = $urandom();
        d_wdata = $urandom();
        d_be = BW'($urandom());
      end
      mem_gnt = $urandom_range(0, 3) != 0;
      mem_rvalid = ids.size() > 0 && $urandom_range(0, 1) != 0;
      mem_rdata = $urandom();
      cycle();
    end

    // reset with two transfers outstanding
    do_reset();
    if_req = 1; if_addr = 32'h40; mem_gnt = 1;
    cycle();
    if_addr = 32'h44;
    cycle();
    d_req = 1; mem_rvalid = 1;
    #2;
    reset = 0;
    #1;
    chk("mid_mem_req", mem_req, 0);
    chk("mid_if_gnt", if_gnt, 0);
    chk("mid_d_gnt", d_gnt, 0);
    chk("mid_if_rv", if_rvalid, 0);
    chk("mid_d_rv", d_rvalid, 0);
    chk("mid_err", err, 0);
    @(posedge clk);
    #1;
    reset = 1;
    ids.delete(); starve = 0; pref_if = 1'b0; err_m = 1'b0;
    if_req = 0; d_req = 0; mem_rvalid = 1;
    cycle();
    mem_rvalid = 0;
    cycle();
    chk("mid_fifo_empty", s_err, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
